// File: rtl/output_error_unit.sv
// Purpose : output-error stage of the learning neuron; waits for the neuron output to settle,
//           then emits backprop = sat(target - axon) and a one-cycle weight-update strobe.
// Latency : a target accepted at edge T0 gives backprop_valid after edge T0+SETTLE_CYCLES+1.
// Backpres: backprop and backprop_valid are held until backprop_ready; sample_ready stays low
//           from acceptance until the handshake, and no second target is buffered.
// Ports   : clock/reset (async, active-high); sample_valid/sample_ready/target/axon on the
//           input side; backprop/backprop_valid/backprop_ready/update_strobe back to the
//           neuron; sample_count, batch_error (ERR_W) and batch_done for training monitoring.
// Option  : define ERROR_CLAMP_EN to further clamp backprop to [-CLAMP_MAG, +CLAMP_MAG].
module output_error_unit #(
  parameter int          SETTLE_CYCLES = 4,
  parameter int          BATCH_SIZE    = 16,
  parameter int          ERR_W         = 48,
  parameter logic [31:0] CLAMP_MAG     = 32'h0001_0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic [31:0]      target,
  input  logic [31:0]      axon,
  output logic [31:0]      backprop,
  output logic             backprop_valid,
  input  logic             backprop_ready,
  output logic             update_strobe,
  output logic [15:0]      sample_count,
  output logic [ERR_W-1:0] batch_error,
  output logic             batch_done
);

`ifdef ERROR_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  localparam int          CNT_W     = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [15:0] LAST_IDX  = 16'(BATCH_SIZE - 1);
  localparam logic [31:0] CLAMP_NEG = ~CLAMP_MAG + 32'd1;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, OUTPUT} state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic [31:0]      target_reg;
  logic [ERR_W-1:0] acc;

  logic [32:0]      diff;
  logic [32:0]      mag;
  logic [31:0]      sat;
  logic [31:0]      bp_next;
  logic [ERR_W:0]   acc_sum;

  assign sample_ready = (state == IDLE);

  always_comb begin
    // 33-bit difference cannot overflow; its magnitude is at most 2^32-1.
    diff = {target_reg[31], target_reg} - {axon[31], axon};
    mag  = diff[32] ? (~diff + 33'd1) : diff;

    // Top two bits disagree -> outside the 32-bit signed range.
    if (diff[32] != diff[31])
      sat = diff[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      sat = diff[31:0];

    bp_next = sat;
    if (CLAMP_ON) begin
      if ($signed(sat) > $signed(CLAMP_MAG))
        bp_next = CLAMP_MAG;
      else if ($signed(sat) < $signed(CLAMP_NEG))
        bp_next = CLAMP_NEG;
    end

    // Extra carry bit detects accumulator overflow for saturation.
    acc_sum = {1'b0, acc} + {{(ERR_W - 32){1'b0}}, mag};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      target_reg     <= '0;
      acc            <= '0;
      backprop       <= '0;
      backprop_valid <= 1'b0;
      update_strobe  <= 1'b0;
      batch_done     <= 1'b0;
      sample_count   <= '0;
      batch_error    <= '0;
    end else begin
      update_strobe <= 1'b0;
      batch_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            target_reg <= target;
            settle_cnt <= CNT_W'(SETTLE_CYCLES);
            if (SETTLE_CYCLES == 0)
              state <= CAPTURE;
            else
              state <= SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - CNT_W'(1);
          if (settle_cnt <= CNT_W'(1))
            state <= CAPTURE;
        end
        CAPTURE: begin
          backprop       <= bp_next;
          backprop_valid <= 1'b1;
          acc            <= acc_sum[ERR_W] ? '1 : acc_sum[ERR_W-1:0];
          state          <= OUTPUT;
        end
        OUTPUT: begin
          if (backprop_ready) begin
            backprop_valid <= 1'b0;
            update_strobe  <= 1'b1;
            if (sample_count == LAST_IDX) begin
              batch_error  <= acc;
              acc          <= '0;
              sample_count <= '0;
              batch_done   <= 1'b1;
            end else begin
              sample_count <= sample_count + 16'd1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_error_unit.sv
// Purpose : directed self-checking bench for output_error_unit (SETTLE_CYCLES=4, BATCH_SIZE=4).
// Latency : expects backprop_valid SETTLE_CYCLES+1 edges after the accepting edge.
// Backpres: exercises a 10-cycle backprop_ready stall with ignored sample_valid pulses.
module tb_output_error_unit;

  localparam int S     = 4;
  localparam int BATCH = 4;
  localparam int ERR_W = 48;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             sample_valid = 1'b0;
  logic             sample_ready;
  logic [31:0]      target = '0;
  logic [31:0]      axon = '0;
  logic [31:0]      backprop;
  logic             backprop_valid;
  logic             backprop_ready = 1'b1;
  logic             update_strobe;
  logic [15:0]      sample_count;
  logic [ERR_W-1:0] batch_error;
  logic             batch_done;

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side batch bookkeeping, fed by hand-computed |diff| per vector.
  int          model_cnt  = 0;
  logic [63:0] model_acc  = '0;
  logic [63:0] model_berr = '0;

  output_error_unit #(
    .SETTLE_CYCLES(S),
    .BATCH_SIZE   (BATCH),
    .ERR_W        (ERR_W),
    .CLAMP_MAG    (32'h0001_0000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .target        (target),
    .axon          (axon),
    .backprop      (backprop),
    .backprop_valid(backprop_valid),
    .backprop_ready(backprop_ready),
    .update_strobe (update_strobe),
    .sample_count  (sample_count),
    .batch_error   (batch_error),
    .batch_done    (batch_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full sample: accept, settle, capture, optional stall, handshake.
  task automatic run_sample(input string tag, input logic [31:0] t, input logic [31:0] a,
                            input logic [31:0] exp_bp, input logic [63:0] exp_mag,
                            input int stall);
    int  lat;
    bit  last;
    backprop_ready = (stall == 0);
    target       = t;
    axon         = a;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check({tag, "_ready_busy"}, sample_ready, 0);
    lat = 0;
    while (!backprop_valid && lat < 50) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, S + 1);
    check({tag, "_backprop"}, backprop, exp_bp);
    for (int i = 0; i < stall; i++) begin
      sample_valid = 1'b1;
      target       = 32'h1234_5678;
      step();
      check({tag, "_stall_valid"}, backprop_valid, 1);
      check({tag, "_stall_bp"}, backprop, exp_bp);
      check({tag, "_stall_strobe"}, update_strobe, 0);
    end
    sample_valid   = 1'b0;
    backprop_ready = 1'b1;

    model_acc = model_acc + exp_mag;
    model_cnt++;
    last = (model_cnt == BATCH);
    if (last) begin
      model_berr = model_acc;
      model_acc  = '0;
      model_cnt  = 0;
    end

    step();
    check({tag, "_strobe"}, update_strobe, 1);
    check({tag, "_done"}, batch_done, last);
    check({tag, "_valid_drop"}, backprop_valid, 0);
    check({tag, "_count"}, sample_count, model_cnt);
    check({tag, "_batch_err"}, batch_error, model_berr);
    step();
    check({tag, "_strobe_end"}, update_strobe, 0);
    check({tag, "_done_end"}, batch_done, 0);
    check({tag, "_ready_idle"}, sample_ready, 1);
  endtask

  logic [31:0] clamp_exp;

  initial begin
`ifdef ERROR_CLAMP_EN
    clamp_exp = 32'h0001_0000;
`else
    clamp_exp = 32'h0005_0000;
`endif
    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("rst_backprop", backprop, 0);
    check("rst_valid", backprop_valid, 0);
    check("rst_strobe", update_strobe, 0);
    check("rst_done", batch_done, 0);
    check("rst_count", sample_count, 0);
    check("rst_batch_err", batch_error, 0);
    reset = 1'b0;
    step();
    check("rst_ready", sample_ready, 1);

    // One sample, then reset mid-SETTLE discards the partial batch.
    run_sample("pre", 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 64'd5, 0);
    check("pre_count_const", sample_count, 1);
    target       = 32'h0000_0100;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    check("mid_settle_ready", sample_ready, 0);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_backprop", backprop, 0);
    check("mid_rst_valid", backprop_valid, 0);
    check("mid_rst_count", sample_count, 0);
    check("mid_rst_strobe", update_strobe, 0);
    #2 reset = 1'b0;
    model_cnt = 0;
    model_acc = '0;
    step();
    check("mid_rst_ready", sample_ready, 1);

    // Batch B: basic, positive saturation, backpressure, clamp.
    run_sample("basic", 32'h0000_0100, 32'h0000_0040, 32'h0000_00C0, 64'h0000_00C0, 0);
    run_sample("sat_pos", 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 64'hFFFF_FFFF, 0);
    run_sample("bpress", 32'h0000_0010, 32'h0000_0030, 32'hFFFF_FFE0, 64'h0000_0020, 10);
    check("bpress_count_const", sample_count, 3);
    run_sample("clamp", 32'h0005_0000, 32'h0000_0000, clamp_exp, 64'h0005_0000, 0);
    check("batchB_err_const", batch_error, 48'h1_0005_00DF);

    // Batch C: errors +5, -3, 0, -7 -> 15.
    run_sample("c0", 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 64'd5, 0);
    run_sample("c1", 32'h0000_0000, 32'h0000_0003, 32'hFFFF_FFFD, 64'd3, 0);
    run_sample("c2", 32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 64'd0, 0);
    run_sample("c3", 32'hFFFF_FFFE, 32'h0000_0005, 32'hFFFF_FFF9, 64'd7, 0);
    check("batchC_err_const", batch_error, 48'd15);
    check("batchC_count_const", sample_count, 0);

    // Batch D starts from zero; negative saturation; batch_error holds.
    run_sample("sat_neg", 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 64'hFFFF_FFFF, 0);
    check("batchD_count_const", sample_count, 1);
    check("batchD_hold_err", batch_error, 48'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
